sprite_line_renderer: RTL and testbench

SPRITE_LINE_RENDERER -- requirements
Module: sprite_line_renderer

---
 rtl/sprite_line_renderer_if.sv | 35 +++
 rtl/sprite_line_renderer.sv | 114 +++++++++++
 tb/tb_sprite_line_renderer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_renderer_if.sv
// sprite_line_renderer_if: sprite attribute, pixel and glyph-ROM signals of the renderer
// slave: renderer side (takes line/sprite/pixel inputs and rom_data, drives rom_addr and pixel results)
// master: host/ROM side
interface sprite_line_renderer_if #(
  parameter int NUM_SPR = 4,
  parameter int ROW_W = 8,
  parameter int ROW_BITS = 4,
  parameter int CODE_W = 7,
  parameter int XY_W = 10
);
  localparam int IW = NUM_SPR > 1 ? $clog2(NUM_SPR) : 1;
  logic line_start;
  logic [XY_W-1:0] next_y;
  logic [NUM_SPR-1:0] spr_en;
  logic [NUM_SPR-1:0] spr_flip;
  logic [NUM_SPR*CODE_W-1:0] spr_code;
  logic [NUM_SPR*XY_W-1:0] spr_x;
  logic [NUM_SPR*XY_W-1:0] spr_y;
  logic [XY_W-1:0] draw_x;
  logic pixel_en;
  logic [CODE_W+ROW_BITS-1:0] rom_addr;
  logic [ROW_W-1:0] rom_data;
  logic pixel_on;
  logic [IW-1:0] pixel_id;
  logic fetch_busy;
  logic overrun;
  modport master (
    output line_start, next_y, spr_en, spr_flip, spr_code, spr_x, spr_y, draw_x, pixel_en, rom_data,
    input rom_addr, pixel_on, pixel_id, fetch_busy, overrun
  );
  modport slave (
    input line_start, next_y, spr_en, spr_flip, spr_code, spr_x, spr_y, draw_x, pixel_en, rom_data,
    output rom_addr, pixel_on, pixel_id, fetch_busy, overrun
  );
endinterface

// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: fetches one glyph row per sprite at line start, then renders prioritized sprite pixels
// clk/rst: clock, asynchronous active-high reset
// bus (slave): line_start/next_y/spr_* snapshot inputs, draw_x/pixel_en pixel query,
//   rom_addr/rom_data glyph ROM port, pixel_on/pixel_id registered result, fetch_busy/overrun status
module sprite_line_renderer #(
  parameter int NUM_SPR = 4,
  parameter int ROW_W = 8,
  parameter int ROW_BITS = 4,
  parameter int CODE_W = 7,
  parameter int XY_W = 10,
  parameter int SCALE = 1
) (
  input logic clk,
  input logic rst,
  sprite_line_renderer_if.slave bus
);
  localparam int IW = NUM_SPR > 1 ? $clog2(NUM_SPR) : 1;
  localparam int CW = $clog2(NUM_SPR + 1);
  typedef enum logic {IDLE, FETCH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [XY_W-1:0] y_q;
  logic [NUM_SPR-1:0] en_q, flip_q;
  logic [NUM_SPR*CODE_W-1:0] code_q;
  logic [NUM_SPR*XY_W-1:0] x_q, sy_q;
  logic [ROW_W-1:0] buf_q [NUM_SPR];
  logic prev_hit_q, prev_flip_q;
  logic cur_hit, cur_flip;
  logic [XY_W-1:0] cur_row;
  logic [CODE_W-1:0] cur_code;
  logic [ROW_W-1:0] rev, row_data;
  logic [XY_W-1:0] col [NUM_SPR];
  logic [ROW_W-1:0] sh [NUM_SPR];
  logic [NUM_SPR-1:0] lit;
  logic [IW-1:0] win;
  logic show;
  always_comb begin
    cur_hit = 1'b0;
    cur_flip = 1'b0;
    cur_row = '0;
    cur_code = '0;
    for (int i = 0; i < NUM_SPR; i++)
      if (cnt_q == CW'(i)) begin
        cur_row = y_q - sy_q[i*XY_W +: XY_W];
        cur_hit = en_q[i] && cur_row[XY_W-1:ROW_BITS] == '0;
        cur_flip = flip_q[i];
        cur_code = code_q[i*CODE_W +: CODE_W];
      end
  end
  always_comb begin
    state_d = bus.line_start ? FETCH : (state_q == FETCH && cnt_q != CW'(NUM_SPR)) ? FETCH : IDLE;
    bus.fetch_busy = state_q == FETCH;
    bus.rom_addr = (state_q == FETCH && cur_hit) ? {cur_code, cur_row[ROW_BITS-1:0]} : '0;
  end
  // ROM data belongs to the channel addressed on the previous cycle
  always_comb begin
    rev = '0;
    for (int b = 0; b < ROW_W; b++) rev[b] = bus.rom_data[ROW_W-1-b];
    row_data = !prev_hit_q ? '0 : prev_flip_q ? rev : bus.rom_data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      prev_hit_q <= 1'b0;
      prev_flip_q <= 1'b0;
      bus.overrun <= 1'b0;
      y_q <= '0;
      en_q <= '0;
      flip_q <= '0;
      code_q <= '0;
      x_q <= '0;
      sy_q <= '0;
      for (int i = 0; i < NUM_SPR; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      bus.overrun <= bus.line_start && state_q == FETCH;
      prev_hit_q <= cur_hit;
      prev_flip_q <= cur_flip;
      if (bus.line_start) begin
        cnt_q <= '0;
        y_q <= bus.next_y;
        en_q <= bus.spr_en;
        flip_q <= bus.spr_flip;
        code_q <= bus.spr_code;
        x_q <= bus.spr_x;
        sy_q <= bus.spr_y;
      end else if (state_q == FETCH) begin
        cnt_q <= state_d == FETCH ? cnt_q + 1'b1 : '0;
        for (int i = 0; i < NUM_SPR; i++)
          if (cnt_q == CW'(i + 1)) buf_q[i] <= row_data;
      end
    end
  always_comb begin
    lit = '0;
    win = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      col[i] = bus.draw_x - x_q[i*XY_W +: XY_W];
      sh[i] = buf_q[i] << (col[i] / XY_W'(SCALE));
      lit[i] = col[i] < XY_W'(ROW_W * SCALE) && sh[i][ROW_W-1];
    end
    for (int i = NUM_SPR - 1; i >= 0; i--)
      if (lit[i]) win = IW'(i);
    show = bus.pixel_en && state_q == IDLE && |lit;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.pixel_on <= 1'b0;
      bus.pixel_id <= '0;
    end else begin
      bus.pixel_on <= show;
      bus.pixel_id <= show ? win : '0;
    end
endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb_sprite_line_renderer: scenario and randomized checks of two renderers (SCALE 1 and 2) against a line-level model
module tb_sprite_line_renderer;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  logic line_start, pixel_en;
  logic [9:0] next_y, draw_x;
  logic [3:0] en, flip;
  logic [27:0] code;
  logic [39:0] sx, sy;
  logic [7:0] rom_mem [2048];
  logic [10:0] addr0;
  logic [63:0] obs_a, obs_b;
  logic [1:0] obs_id [64];
  sprite_line_renderer_if a ();
  sprite_line_renderer_if b ();
  assign a.line_start = line_start;
  assign a.next_y = next_y;
  assign a.spr_en = en;
  assign a.spr_flip = flip;
  assign a.spr_code = code;
  assign a.spr_x = sx;
  assign a.spr_y = sy;
  assign a.draw_x = draw_x;
  assign a.pixel_en = pixel_en;
  assign b.line_start = line_start;
  assign b.next_y = next_y;
  assign b.spr_en = en;
  assign b.spr_flip = flip;
  assign b.spr_code = code;
  assign b.spr_x = sx;
  assign b.spr_y = sy;
  assign b.draw_x = draw_x;
  assign b.pixel_en = pixel_en;
  always @(posedge clk) begin
    a.rom_data <= rom_mem[a.rom_addr];
    b.rom_data <= rom_mem[b.rom_addr];
  end
  sprite_line_renderer #(.SCALE(1)) d1 (.clk(clk), .rst(rst), .bus(a));
  sprite_line_renderer #(.SCALE(2)) d2 (.clk(clk), .rst(rst), .bus(b));
  logic [7:0] m_buf [N];
  logic [9:0] m_y;
  logic [9:0] m_sx [N];
  logic [9:0] m_sy [N];
  logic [6:0] m_code [N];
  logic m_en [N];
  logic m_flip [N];
  function automatic logic m_hit(int k);
    logic [9:0] row = m_y - m_sy[k];
    return m_en[k] && row < 16;
  endfunction
  function automatic logic [10:0] m_addr(int k);
    logic [9:0] row = m_y - m_sy[k];
    return m_hit(k) ? {m_code[k], row[3:0]} : 11'd0;
  endfunction
  task automatic m_snapshot();
    m_y = next_y;
    for (int k = 0; k < N; k++) begin
      m_sx[k] = sx[k*10 +: 10];
      m_sy[k] = sy[k*10 +: 10];
      m_code[k] = code[k*7 +: 7];
      m_en[k] = en[k];
      m_flip[k] = flip[k];
    end
    for (int k = 0; k < N; k++) begin
      logic [7:0] d = rom_mem[m_addr(k)];
      logic [7:0] r;
      for (int j = 0; j < 8; j++) r[j] = d[7-j];
      m_buf[k] = !m_hit(k) ? 8'd0 : m_flip[k] ? r : d;
    end
  endtask
  task automatic m_pixel(input int s, input logic [9:0] dx, input logic pe, output logic on, output logic [1:0] id);
    on = 1'b0;
    id = 2'd0;
    if (pe)
      for (int k = N - 1; k >= 0; k--) begin
        logic [9:0] t = dx - m_sx[k];
        int c = int'(t);
        logic [7:0] bb = m_buf[k];
        if (c < 8 * s && bb[3'(7 - c / s)]) begin
          on = 1'b1;
          id = 2'(k);
        end
      end
  endtask
  task automatic clear_spr();
    en = '0;
    flip = '0;
    code = '0;
    sx = '0;
    sy = '0;
    next_y = '0;
  endtask
  task automatic put(input int k, input logic [6:0] c, input logic [9:0] x, input logic [9:0] y);
    en[k] = 1'b1;
    code[k*7 +: 7] = c;
    sx[k*10 +: 10] = x;
    sy[k*10 +: 10] = y;
  endtask
  task automatic do_line(input logic [9:0] y);
    @(negedge clk);
    next_y = y;
    line_start = 1'b1;
    pixel_en = 1'b0;
    m_snapshot();
    for (int k = 0; k <= N; k++) begin
      @(negedge clk);
      line_start = 1'b0;
      if (k == 0) begin
        addr0 = a.rom_addr;
        en = 4'($urandom);
        flip = 4'($urandom);
        code = 28'($urandom);
        sx = {8'($urandom), 32'($urandom)};
        sy = {8'($urandom), 32'($urandom)};
        next_y = 10'($urandom);
      end
      tests++;
      if (a.fetch_busy !== 1'b1 || b.fetch_busy !== 1'b1) begin
        fails++;
        $display("FAIL busy_in_fetch k=%0d got a=%b b=%b exp=1", k, a.fetch_busy, b.fetch_busy);
      end
      if (k < N) begin
        tests++;
        if (a.rom_addr !== m_addr(k) || b.rom_addr !== m_addr(k)) begin
          fails++;
          $display("FAIL rom_addr k=%0d got a=%h b=%h exp=%h", k, a.rom_addr, b.rom_addr, m_addr(k));
        end
      end
      if (k > 0) begin
        tests++;
        if (a.pixel_on !== 1'b0 || b.pixel_on !== 1'b0) begin
          fails++;
          $display("FAIL pixel_during_fetch k=%0d got a=%b b=%b exp=0", k, a.pixel_on, b.pixel_on);
        end
      end
      pixel_en = 1'b1;
      draw_x = 10'($urandom);
    end
    @(negedge clk);
    pixel_en = 1'b0;
    tests++;
    if (a.fetch_busy !== 1'b0 || b.fetch_busy !== 1'b0 || a.pixel_on !== 1'b0 || b.pixel_on !== 1'b0) begin
      fails++;
      $display("FAIL fetch_end got busy a=%b b=%b pix a=%b b=%b exp all 0", a.fetch_busy, b.fetch_busy, a.pixel_on, b.pixel_on);
    end
  endtask
  task automatic scan(input logic [9:0] start, input int len, input bit rand_en);
    logic [9:0] pdx;
    logic ppe, eo, eo2;
    logic [1:0] ei, ei2;
    obs_a = '0;
    obs_b = '0;
    pdx = '0;
    ppe = 1'b0;
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      if (i > 0) begin
        m_pixel(1, pdx, ppe, eo, ei);
        m_pixel(2, pdx, ppe, eo2, ei2);
        tests++;
        if (a.pixel_on !== eo || a.pixel_id !== ei) begin
          fails++;
          $display("FAIL pixel_s1 x=%0d en=%b got on=%b id=%0d exp on=%b id=%0d", pdx, ppe, a.pixel_on, a.pixel_id, eo, ei);
        end
        tests++;
        if (b.pixel_on !== eo2 || b.pixel_id !== ei2) begin
          fails++;
          $display("FAIL pixel_s2 x=%0d en=%b got on=%b id=%0d exp on=%b id=%0d", pdx, ppe, b.pixel_on, b.pixel_id, eo2, ei2);
        end
        if (i <= 64) begin
          obs_a[i-1] = a.pixel_on;
          obs_b[i-1] = b.pixel_on;
          obs_id[i-1] = a.pixel_id;
        end
      end
      if (i < len) begin
        draw_x = start + 10'(i);
        pixel_en = rand_en ? ($urandom % 4 != 0) : 1'b1;
        pdx = draw_x;
        ppe = pixel_en;
      end else pixel_en = 1'b0;
    end
  endtask
  task automatic check_zero(input string name);
    tests++;
    if ({a.pixel_on, a.pixel_id, a.fetch_busy, a.overrun, a.rom_addr, b.pixel_on, b.pixel_id, b.fetch_busy, b.overrun, b.rom_addr} !== '0) begin
      fails++;
      $display("FAIL %s got a on=%b id=%0d busy=%b ovr=%b addr=%h b on=%b id=%0d busy=%b ovr=%b addr=%h exp all 0", name,
               a.pixel_on, a.pixel_id, a.fetch_busy, a.overrun, a.rom_addr, b.pixel_on, b.pixel_id, b.fetch_busy, b.overrun, b.rom_addr);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    for (int k = 0; k < N; k++) m_buf[k] = 8'd0;
    rst = 1'b0;
    @(negedge clk);
    check_zero("after_release");
  endtask
  task automatic test_basic_hit();
    clear_spr();
    put(0, 7'd1, 10'd50, 10'd100);
    rom_mem[11'h14] = 8'b10100101;
    do_line(10'd104);
    tests++;
    if (addr0 !== 11'h014) begin
      fails++;
      $display("FAIL basic_addr got %h exp 014", addr0);
    end
    scan(10'd50, 8, 1'b0);
    tests++;
    if (obs_a[7:0] !== 8'b10100101) begin
      fails++;
      $display("FAIL basic_pattern got %b exp 10100101 (bit0=x50)", obs_a[7:0]);
    end
    scan(10'd40, 24, 1'b1);
  endtask
  task automatic test_flip_scale();
    clear_spr();
    put(0, 7'd1, 10'd50, 10'd100);
    flip[0] = 1'b1;
    rom_mem[11'h14] = 8'b11000000;
    do_line(10'd104);
    scan(10'd48, 22, 1'b0);
    tests++;
    if (obs_b[21:0] !== 22'h03C000) begin
      fails++;
      $display("FAIL flip_scale2 got %h exp 03c000 (bit0=x48)", obs_b[21:0]);
    end
  endtask
  task automatic test_row_miss();
    clear_spr();
    put(0, 7'd1, 10'd50, 10'd100);
    rom_mem[11'h10] = 8'hFF;
    rom_mem[11'h14] = 8'hFF;
    do_line(10'd116);
    tests++;
    if (addr0 !== 11'd0) begin
      fails++;
      $display("FAIL miss_row_addr got %h exp 000", addr0);
    end
    scan(10'd48, 12, 1'b0);
    tests++;
    if (obs_a[11:0] !== 12'd0) begin
      fails++;
      $display("FAIL miss_row_pixels got %h exp 000", obs_a[11:0]);
    end
    clear_spr();
    put(0, 7'd1, 10'd50, 10'd100);
    en[0] = 1'b0;
    do_line(10'd104);
    tests++;
    if (addr0 !== 11'd0) begin
      fails++;
      $display("FAIL miss_en_addr got %h exp 000", addr0);
    end
    scan(10'd48, 12, 1'b0);
    tests++;
    if (obs_a[11:0] !== 12'd0) begin
      fails++;
      $display("FAIL miss_en_pixels got %h exp 000", obs_a[11:0]);
    end
  endtask
  task automatic test_priority();
    clear_spr();
    put(1, 7'd5, 10'd200, 10'd300);
    put(3, 7'd9, 10'd195, 10'd300);
    rom_mem[{7'd5, 4'd2}] = 8'hFF;
    rom_mem[{7'd9, 4'd2}] = 8'hFF;
    do_line(10'd302);
    scan(10'd190, 20, 1'b0);
    tests++;
    if (obs_a[10] !== 1'b1 || obs_id[10] !== 2'd1) begin
      fails++;
      $display("FAIL priority_x200 got on=%b id=%0d exp on=1 id=1", obs_a[10], obs_id[10]);
    end
  endtask
  task automatic test_overrun();
    clear_spr();
    put(0, 7'd1, 10'd50, 10'd100);
    put(1, 7'd3, 10'd60, 10'd100);
    rom_mem[11'h14] = 8'hA5;
    rom_mem[{7'd3, 4'd4}] = 8'hFF;
    rom_mem[{7'd2, 4'd4}] = 8'h3C;
    @(negedge clk);
    next_y = 10'd104;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    tests++;
    if (a.overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_early got %b exp 0", a.overrun);
    end
    clear_spr();
    put(0, 7'd2, 10'd80, 10'd100);
    put(2, 7'd3, 10'd90, 10'd100);
    next_y = 10'd104;
    @(negedge clk);
    line_start = 1'b1;
    m_snapshot();
    for (int k = 0; k <= N; k++) begin
      @(negedge clk);
      line_start = 1'b0;
      tests++;
      if (a.overrun !== (k == 0) || b.overrun !== (k == 0)) begin
        fails++;
        $display("FAIL overrun_pulse k=%0d got a=%b b=%b exp %b", k, a.overrun, b.overrun, k == 0);
      end
      tests++;
      if (a.fetch_busy !== 1'b1 || a.rom_addr !== (k < N ? m_addr(k) : 11'd0)) begin
        fails++;
        $display("FAIL overrun_refetch k=%0d got busy=%b addr=%h exp busy=1 addr=%h", k, a.fetch_busy, a.rom_addr, k < N ? m_addr(k) : 11'd0);
      end
    end
    @(negedge clk);
    tests++;
    if (a.fetch_busy !== 1'b0) begin
      fails++;
      $display("FAIL overrun_done got busy=%b exp 0", a.fetch_busy);
    end
    scan(10'd45, 55, 1'b0);
  endtask
  task automatic test_reset_mid_fetch();
    clear_spr();
    put(0, 7'd1, 10'd50, 10'd100);
    put(2, 7'd3, 10'd52, 10'd100);
    rom_mem[11'h14] = 8'hA5;
    rom_mem[{7'd3, 4'd4}] = 8'hFF;
    do_line(10'd104);
    scan(10'd48, 16, 1'b0);
    clear_spr();
    put(0, 7'd1, 10'd50, 10'd100);
    put(2, 7'd3, 10'd52, 10'd100);
    @(negedge clk);
    next_y = 10'd104;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (a.rom_addr !== {7'd3, 4'd4}) begin
      fails++;
      $display("FAIL midfetch_addr got %h exp %h", a.rom_addr, {7'd3, 4'd4});
    end
    rst = 1'b1;
    #1;
    check_zero("reset_same_cycle");
    for (int k = 0; k < N; k++) m_buf[k] = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero("idle_after_reset");
    end
    scan(10'd48, 16, 1'b0);
    clear_spr();
    put(0, 7'd1, 10'd50, 10'd100);
    do_line(10'd104);
    scan(10'd48, 12, 1'b0);
  endtask
  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic [9:0] ny = 10'($urandom);
      logic [9:0] st;
      clear_spr();
      for (int k = 0; k < N; k++) begin
        en[k] = $urandom % 4 != 0;
        flip[k] = 1'($urandom);
        code[k*7 +: 7] = 7'($urandom);
        sy[k*10 +: 10] = ny - 10'($urandom_range(0, 20));
        sx[k*10 +: 10] = (it % 3 == 0) ? 10'(1016 + $urandom_range(0, 10)) : 10'($urandom_range(100, 140));
      end
      st = (it % 3 == 0) ? 10'd1010 : 10'd96;
      do_line(ny);
      scan(st, 56, 1'b1);
    end
  endtask
  initial begin
    rst = 1'b1;
    line_start = 1'b0;
    pixel_en = 1'b0;
    draw_x = '0;
    clear_spr();
    for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
    test_reset();
    test_basic_hit();
    test_flip_scale();
    test_row_miss();
    test_priority();
    test_overrun();
    test_reset_mid_fetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
